// File: rtl/cam_multibuf_wr_if.sv
// Camera-side input and BRAM write-side output bundle for cam_multibuf_wr.
interface cam_multibuf_wr_if #(
  parameter int NUM_BUF = 2,
  parameter int BPP     = 2,
  parameter int ADDR_W  = 17,
  parameter int BUF_W   = 2
);
  localparam int PIX_W = 8 * BPP;

  logic               en_i;
  logic               cam_vsync_i;
  logic               cam_hsync_i;
  logic [7:0]         cam_data_i;
  logic [NUM_BUF-1:0] buf_rel_i;
  logic               ram_wr_en_o;
  logic [BUF_W-1:0]   ram_wr_buf_o;
  logic [ADDR_W-1:0]  ram_wr_addr_o;
  logic [PIX_W-1:0]   ram_wr_data_o;
  logic [NUM_BUF-1:0] buf_full_o;
  logic               fr_done_o;
  logic [BUF_W-1:0]   fr_done_buf_o;
  logic               fr_drop_o;
  logic               fr_err_o;

  modport master (
    output en_i, cam_vsync_i, cam_hsync_i, cam_data_i, buf_rel_i,
    input  ram_wr_en_o, ram_wr_buf_o, ram_wr_addr_o, ram_wr_data_o,
           buf_full_o, fr_done_o, fr_done_buf_o, fr_drop_o, fr_err_o
  );

  modport slave (
    input  en_i, cam_vsync_i, cam_hsync_i, cam_data_i, buf_rel_i,
    output ram_wr_en_o, ram_wr_buf_o, ram_wr_addr_o, ram_wr_data_o,
           buf_full_o, fr_done_o, fr_done_buf_o, fr_drop_o, fr_err_o
  );
endinterface

// File: rtl/cam_multibuf_wr.sv
// Camera-domain frame writer: packs DVP bytes into pixels and writes whole
// frames round-robin into NUM_BUF frame buffers, with drop and error handling.
//
// state | meaning
// IDLE  | capture disabled, waiting for enable during vertical blank
// SYNC  | in blank, waiting for vsync fall to start a frame
// CAP   | frame active, writing pixels into buffer r_sel
// DROP  | frame active, no free buffer, discarding
module cam_multibuf_wr #(
  parameter int H_ACT   = 480,
  parameter int V_ACT   = 272,
  parameter int NUM_BUF = 2,
  parameter int BPP     = 2,
  parameter int ADDR_W  = 17,
  parameter int BUF_W   = 2
) (
  input  logic                iClk,
  input  logic                iRst,
  cam_multibuf_wr_if.slave    bus
);
  localparam int PIX_W = 8 * BPP;
  localparam int XW    = $clog2(H_ACT + 1);
  localparam int YW    = $clog2(V_ACT + 2);

  localparam logic [XW-1:0]     L_H    = XW'(H_ACT);
  localparam logic [YW-1:0]     L_V    = YW'(V_ACT);
  localparam logic [YW-1:0]     L_VSAT = YW'(V_ACT + 1);
  localparam logic [ADDR_W-1:0] L_HA   = ADDR_W'(H_ACT);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_CAP, S_DROP} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_vs_d, r_hs_d;
  logic               r_phase;
  logic [7:0]         r_hi;
  logic [XW-1:0]      r_x;
  logic [YW-1:0]      r_y;
  logic [ADDR_W-1:0]  r_line_base;
  logic               r_err;
  logic [BUF_W-1:0]   r_sel, r_last;
  logic [NUM_BUF-1:0] r_full;
  logic               r_wr_en;
  logic [BUF_W-1:0]   r_wr_buf;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [PIX_W-1:0]   r_wr_data;
  logic               r_done, r_drop, r_ferr;
  logic [BUF_W-1:0]   r_done_buf;

  logic               w_samp, w_pix_done, w_vs_fall, w_vs_rise;
  logic               w_line_end, w_line_err, w_err_fin;
  logic [YW-1:0]      w_y_inc, w_y_fin;
  logic               w_found;
  logic [BUF_W-1:0]   w_pick;
  int                 w_idx;
  logic               w_start, w_commit, w_reject, w_drop;
  logic [NUM_BUF-1:0] w_set;
  logic [PIX_W-1:0]   w_pix;

  assign w_samp     = bus.cam_hsync_i && !bus.cam_vsync_i;
  assign w_pix_done = w_samp && ((BPP == 1) || r_phase);
  assign w_vs_fall  = r_vs_d && !bus.cam_vsync_i;
  assign w_vs_rise  = !r_vs_d && bus.cam_vsync_i;
  assign w_line_end = r_hs_d && !bus.cam_hsync_i;
  assign w_line_err = r_phase || (r_x < L_H);
  assign w_y_inc    = (r_y == L_VSAT) ? r_y : r_y + 1'b1;
  // A line may end in the same cycle vsync rises; fold its result into the verdict.
  assign w_err_fin  = r_err || (w_line_end && w_line_err);
  assign w_y_fin    = w_line_end ? w_y_inc : r_y;

  generate
    if (BPP == 2) begin : g_bpp2
      assign w_pix = {r_hi, bus.cam_data_i};
    end else begin : g_bpp1
      assign w_pix = bus.cam_data_i;
    end
  endgenerate

  // First free buffer after the last committed one; registered flags only.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int i = NUM_BUF; i >= 1; i--) begin
      w_idx = (int'(r_last) + i) % NUM_BUF;
      if (!r_full[w_idx[BUF_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[BUF_W-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and frame-level events.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_commit    = 1'b0;
    w_reject    = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_IDLE: if (bus.en_i && bus.cam_vsync_i) w_state_nxt = S_SYNC;
      S_SYNC: begin
        if (!bus.en_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_vs_fall) begin
          if (w_found) begin
            w_state_nxt = S_CAP;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = S_DROP;
          end
        end
      end
      S_CAP: if (w_vs_rise) begin
        w_state_nxt = S_SYNC;
        if (!w_err_fin && (w_y_fin == L_V)) w_commit = 1'b1;
        else                                w_reject = 1'b1;
      end
      S_DROP: if (w_vs_rise) begin
        w_state_nxt = S_SYNC;
        w_drop      = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Full-flag set mask for the buffer being committed.
  always_comb begin
    w_set = '0;
    if (w_commit) w_set[r_sel] = 1'b1;
  end

  // Byte packing, pixel/line counters, write strobe and frame pulses.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_vs_d      <= 1'b0;
      r_hs_d      <= 1'b0;
      r_phase     <= 1'b0;
      r_hi        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_line_base <= '0;
      r_err       <= 1'b0;
      r_sel       <= '0;
      r_last      <= BUF_W'(NUM_BUF - 1);
      r_full      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_buf    <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_done      <= 1'b0;
      r_done_buf  <= '0;
      r_drop      <= 1'b0;
      r_ferr      <= 1'b0;
    end else begin
      r_vs_d  <= bus.cam_vsync_i;
      r_hs_d  <= bus.cam_hsync_i;
      r_wr_en <= 1'b0;
      r_done  <= w_commit;
      r_ferr  <= w_reject;
      r_drop  <= w_drop;
      r_full  <= (r_full & ~bus.buf_rel_i) | w_set;

      if (!bus.cam_hsync_i) begin
        r_phase <= 1'b0;
      end else if (w_samp && (BPP == 2)) begin
        r_phase <= ~r_phase;
        if (!r_phase) r_hi <= bus.cam_data_i;
      end

      if (w_start) begin
        r_sel       <= w_pick;
        r_x         <= '0;
        r_y         <= '0;
        r_line_base <= '0;
        r_err       <= 1'b0;
      end else if (r_state == S_CAP) begin
        if (w_pix_done) begin
          if ((r_x < L_H) && (r_y < L_V)) begin
            r_wr_en   <= 1'b1;
            r_wr_buf  <= r_sel;
            r_wr_addr <= r_line_base + ADDR_W'(r_x);
            r_wr_data <= w_pix;
          end else begin
            r_err <= 1'b1;
          end
          if (r_x != L_H) r_x <= r_x + 1'b1;
        end
        if (w_line_end) begin
          r_x <= '0;
          r_y <= w_y_inc;
          if (r_y < L_V) r_line_base <= r_line_base + L_HA;
          if (w_line_err) r_err <= 1'b1;
        end
      end

      if (w_commit) begin
        r_last     <= r_sel;
        r_done_buf <= r_sel;
      end
    end
  end

  assign bus.ram_wr_en_o   = r_wr_en;
  assign bus.ram_wr_buf_o  = r_wr_buf;
  assign bus.ram_wr_addr_o = r_wr_addr;
  assign bus.ram_wr_data_o = r_wr_data;
  assign bus.buf_full_o    = r_full;
  assign bus.fr_done_o     = r_done;
  assign bus.fr_done_buf_o = r_done_buf;
  assign bus.fr_drop_o     = r_drop;
  assign bus.fr_err_o      = r_ferr;
endmodule
